mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Owns the byte-wide RAM/IO port; arbitrates instruction fetch, load and store requesters onto it.
//  Serialises each granted request into 1..4 byte accesses, assembles/extends read data, splits writes.
//  Sits between the fetch unit / load-store buffer and the top-level mem_a/mem_wr/mem_din/mem_dout pins.
// PARAMETERS
//  DATA_BURST  2         max consecutive load/store grants while if_req is pending before fetch is forced
//  IO_BASE     32'h30000 addresses >= IO_BASE are IO; IO writes obey io_buffer_full
// PORTS
//  clk             in  1   clock, all state on posedge
//  rst             in  1   reset, asynchronous, active-low
//  rdy             in  1   0 = freeze all state, mem_wr forced 0
//  clear           in  1   pipeline flush (mispredict)
//  io_buffer_full  in  1   1 = IO write must not be issued this cycle
//  if_req/if_addr  in  1/32  fetch request, 4-byte read, held until if_done
//  if_done         out 1   1-cycle pulse; if_data valid same cycle
//  if_data         out 32  little-endian instruction word
//  ld_req/ld_addr  in  1/32  load request, held until ld_done
//  ld_size         in  2   0=byte 1=half 2=word (3 illegal, treated as word)
//  ld_signed       in  1   1 = sign-extend, 0 = zero-extend
//  ld_done/ld_data out 1/32  pulse + extended result
//  st_req/st_addr  in  1/32  committed store request, held until st_done
//  st_size/st_data in  2/32  size as ld_size; low bytes written first
//  st_done         out 1   1-cycle pulse after last byte written
//  mem_a           out 32  byte address to RAM/IO
//  mem_wr          out 1   1 = write mem_dout at mem_a this cycle
//  mem_dout/mem_din out/in 8  write byte / read byte (valid one cycle after its address)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all outputs 0, burst counter 0, cur byte index 0.
//  mem_a=0, mem_wr=0 in IDLE/DONE: never a spurious write; mem_wr=1 only in WRITE with issued byte.
//  FSM IDLE -> READ | WRITE -> (READ only) READ_TAIL -> DONE -> IDLE.
//  Arbitration in IDLE (one grant per cycle): st_req > ld_req > if_req, except when burst counter
//   == DATA_BURST and if_req=1 -> fetch wins. Counter +1 on each data grant while if_req=1,
//   cleared on fetch grant or when if_req=0. Saturates at DATA_BURST.
//  Grant latches addr, size, kind, st_data; requester inputs ignored thereafter.
//  READ, N bytes: cycles G+1..G+N drive mem_a=addr+k (k=0..N-1); byte k captured at G+k+2
//   into bits [8k+7:8k]; done pulse at G+N+2 (word: 6 cycles after grant cycle G). Back to IDLE G+N+3.
//  WRITE, N bytes: cycles G+1..G+N drive mem_a=addr+k, mem_dout=st_data[8k+7:8k], mem_wr=1;
//   st_done pulse at G+N+1.
//  IO write (addr >= IO_BASE) with io_buffer_full=1: hold byte index, mem_wr=0, retry next cycle.
//  Extension: byte/half results sign- or zero-extended per ld_signed; if_data never extended.
//  Address wrap: addr+k wraps mod 2^32, no fault.
//  clear=1: READ/READ_TAIL (fetch or load) -> IDLE next cycle, no done pulse, burst counter 0;
//   WRITE continues to completion and st_done still pulses (store is committed).
//   clear in IDLE with st_req=1: store still granted; ld_req/if_req ignored that cycle.
//  rdy=0: no state change, no done pulse emitted, captured data preserved; resumes exactly.
//  Done pulse and new grant never overlap: next grant earliest in the cycle after DONE.
// STRUCTURE
//  mem_pkg: size encodings (SZ_B/SZ_H/SZ_W), kind enum (K_IF/K_LD/K_ST), FSM state enum, IO_BASE default.
//  Sub-module mem_byte_pack: comb byte-count from size, byte lane select for writes,
//   sign/zero extension of assembled read word. FSM, arbitration, counters stay in mem_arbiter.
// TESTING
//  LW 0x100, RAM 11 22 33 44 -> mem_a 100..103, ld_done 6 cyc after grant, ld_data=0x44332211.
//  LB signed 0x200=0x80 -> 0xFFFFFF80; LHU 0x200=80 FF -> 0x0000FF80; ld_done at G+3/G+4.
//  SH 0x300 data 0xAABBCCDD -> writes DD@300, CC@301, mem_wr 2 cycles, st_done G+3; RAM 302 untouched.
//  if_req,ld_req held continuously with 3 loads queued -> grants LD,LD,IF,LD (DATA_BURST=2).
//  clear during LW byte 2 -> no ld_done, IDLE next cycle; clear during SW -> all 4 bytes, st_done pulses.
//  SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 those cycles, write on 4th, then st_done.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the byte-wide memory arbiter: access sizes, requester kinds, FSM states.
package mem_pkg;

   localparam logic [1:0]  SZ_B        = 2'd0;
   localparam logic [1:0]  SZ_H        = 2'd1;
   localparam logic [1:0]  SZ_W        = 2'd2;
   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

   typedef enum logic [1:0] {K_IF, K_LD, K_ST} kind_e;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_READ_TAIL, S_WRITE, S_DONE} state_e;

endpackage

// File: rtl/mem_byte_pack.sv
// Byte-level helpers for the arbiter: byte count per access size, write lane select,
// and sign/zero extension of an assembled read word.
module mem_byte_pack
   import mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  idx_i,
   input  logic        signed_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] rd_word_i,
   output logic [2:0]  nbytes_o,
   output logic [7:0]  wr_byte_o,
   output logic [31:0] ext_word_o
);

   function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                          input logic sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = signed'(w[7:0]);
      h = signed'(w[15:0]);
      case (sz)
         SZ_B:    extend = sgn ? 32'(b) : {24'd0, w[7:0]};
         SZ_H:    extend = sgn ? 32'(h) : {16'd0, w[15:0]};
         default: extend = w;
      endcase
   endfunction

   always_comb begin
      case (size_i)
         SZ_B:    nbytes_o = 3'd1;
         SZ_H:    nbytes_o = 3'd2;
         default: nbytes_o = 3'd4;   // encoding 3 behaves as a word
      endcase
      wr_byte_o  = st_data_i[{idx_i, 3'b000} +: 8];
      ext_word_o = extend(rd_word_i, size_i, signed_i);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Owns the byte-wide RAM/IO port: arbitrates fetch, load and store requests and
// serialises each grant into 1..4 byte accesses.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned DATA_BURST = 2,
   parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rdy_i,
   input  logic        clear_i,
   input  logic        io_buffer_full_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_done_o,
   output logic [31:0] if_data_o,
   input  logic        ld_req_i,
   input  logic [31:0] ld_addr_i,
   input  logic [1:0]  ld_size_i,
   input  logic        ld_signed_i,
   output logic        ld_done_o,
   output logic [31:0] ld_data_o,
   input  logic        st_req_i,
   input  logic [31:0] st_addr_i,
   input  logic [1:0]  st_size_i,
   input  logic [31:0] st_data_i,
   output logic        st_done_o,
   output logic [31:0] mem_a_o,
   output logic        mem_wr_o,
   output logic [7:0]  mem_dout_o,
   input  logic [7:0]  mem_din_i
);

   localparam logic [7:0] BURST_MAX = 8'(DATA_BURST);

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q;
   logic [1:0]  size_q, size_d, idx_q, idx_d, pidx_q, pidx_d;
   logic        sgn_q, sgn_d, pend_q, pend_d;
   logic [7:0]  burst_q, burst_d;
   logic [2:0]  nbytes;
   logic [7:0]  wr_byte;
   logic [31:0] cur_a, ext_word;
   logic        last, io_blocked, grant_st, grant_ld, grant_if;

   mem_byte_pack u_pack (
      .size_i     (size_q),
      .idx_i      (idx_q),
      .signed_i   (sgn_q),
      .st_data_i  (wdata_q),
      .rd_word_i  (data_q),
      .nbytes_o   (nbytes),
      .wr_byte_o  (wr_byte),
      .ext_word_o (ext_word)
   );

   assign cur_a      = addr_q + {30'd0, idx_q};
   assign last       = ({1'b0, idx_q} == nbytes - 3'd1);
   assign io_blocked = (cur_a >= IO_BASE) && io_buffer_full_i;
   assign if_data_o  = data_q;
   assign ld_data_o  = ext_word;

   // A flush drops speculative fetch/load requests but never a committed store.
   always_comb begin
      grant_st = 1'b0;
      grant_ld = 1'b0;
      grant_if = 1'b0;
      if (state_q == S_IDLE) begin
         if (clear_i)                                grant_st = st_req_i;
         else if (if_req_i && burst_q == BURST_MAX)  grant_if = 1'b1;
         else if (st_req_i)                          grant_st = 1'b1;
         else if (ld_req_i)                          grant_ld = 1'b1;
         else                                        grant_if = if_req_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      addr_d     = addr_q;
      size_d     = size_q;
      sgn_d      = sgn_q;
      wdata_d    = wdata_q;
      idx_d      = idx_q;
      pidx_d     = pidx_q;
      pend_d     = 1'b0;
      burst_d    = burst_q;
      mem_a_o    = '0;
      mem_wr_o   = 1'b0;
      mem_dout_o = '0;
      if_done_o  = 1'b0;
      ld_done_o  = 1'b0;
      st_done_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (grant_st) begin
               state_d = S_WRITE;  kind_d = K_ST;  addr_d = st_addr_i;
               size_d  = st_size_i; sgn_d = 1'b0; wdata_d = st_data_i;
            end else if (grant_ld) begin
               state_d = S_READ;   kind_d = K_LD;  addr_d = ld_addr_i;
               size_d  = ld_size_i; sgn_d = ld_signed_i;
            end else if (grant_if) begin
               state_d = S_READ;   kind_d = K_IF;  addr_d = if_addr_i;
               size_d  = SZ_W;     sgn_d  = 1'b0;
            end
            if (grant_if)
               burst_d = '0;
            else if ((grant_st || grant_ld) && if_req_i && burst_q != BURST_MAX)
               burst_d = burst_q + 8'd1;
         end
         S_READ: begin
            mem_a_o = cur_a;
            if (clear_i) begin
               state_d = S_IDLE;
               burst_d = '0;
            end else begin
               pend_d = 1'b1;
               pidx_d = idx_q;
               if (last) state_d = S_READ_TAIL;
               else      idx_d   = idx_q + 2'd1;
            end
         end
         S_READ_TAIL: begin
            if (clear_i) begin
               state_d = S_IDLE;
               burst_d = '0;
            end else begin
               state_d = S_DONE;
            end
         end
         S_WRITE: begin
            mem_a_o = cur_a;
            if (!io_blocked) begin
               mem_wr_o   = 1'b1;
               mem_dout_o = wr_byte;
               if (last) state_d = S_DONE;
               else      idx_d   = idx_q + 2'd1;
            end
         end
         S_DONE: begin
            if_done_o = (kind_q == K_IF);
            ld_done_o = (kind_q == K_LD);
            st_done_o = (kind_q == K_ST);
            state_d   = S_IDLE;
            idx_d     = '0;
         end
         default: state_d = S_IDLE;
      endcase
      if (!if_req_i) burst_d = '0;
      // While frozen, keep presenting the address whose byte is still owed so
      // mem_din carries that byte when the pipeline resumes.
      if (!rdy_i) begin
         mem_wr_o   = 1'b0;
         mem_dout_o = '0;
         if_done_o  = 1'b0;
         ld_done_o  = 1'b0;
         st_done_o  = 1'b0;
         if (pend_q) mem_a_o = addr_q + {30'd0, pidx_q};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         kind_q  <= K_IF;
         addr_q  <= '0;
         size_q  <= '0;
         sgn_q   <= 1'b0;
         wdata_q <= '0;
         idx_q   <= '0;
         pidx_q  <= '0;
         pend_q  <= 1'b0;
         burst_q <= '0;
         data_q  <= '0;
      end else if (rdy_i) begin
         state_q <= state_d;
         kind_q  <= kind_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         pidx_q  <= pidx_d;
         pend_q  <= pend_d;
         burst_q <= burst_d;
         if (pend_q) data_q[{pidx_q, 3'b000} +: 8] <= mem_din_i;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a byte-array memory model.
module tb_mem_arbiter;
   import mem_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clear = 1'b0, io_full = 1'b0;
   logic        if_req = 1'b0, ld_req = 1'b0, ld_signed = 1'b0, st_req = 1'b0;
   logic [31:0] if_addr = '0, ld_addr = '0, st_addr = '0, st_data = '0;
   logic [1:0]  ld_size = '0, st_size = '0;
   logic        if_done, ld_done, st_done, mem_wr;
   logic [31:0] if_data, ld_data, mem_a;
   logic [7:0]  mem_dout, mem_din;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_BURST(2), .IO_BASE(32'h0003_0000)) dut (
      .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .clear_i(clear), .io_buffer_full_i(io_full),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_data_o(if_data),
      .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_size_i(ld_size), .ld_signed_i(ld_signed),
      .ld_done_o(ld_done), .ld_data_o(ld_data),
      .st_req_i(st_req), .st_addr_i(st_addr), .st_size_i(st_size), .st_data_i(st_data),
      .st_done_o(st_done), .mem_a_o(mem_a), .mem_wr_o(mem_wr), .mem_dout_o(mem_dout),
      .mem_din_i(mem_din)
   );

   // 64 KiB RAM image (address taken mod 2^16); read data valid one cycle after address.
   logic [7:0]  ram    [0:65535];
   logic [7:0]  shadow [0:65535];
   logic        pre_we = 1'b0;
   logic [15:0] pre_a  = '0;
   logic [7:0]  pre_d  = '0;

   always @(posedge clk) begin
      mem_din <= ram[mem_a[15:0]];
      if (pre_we)      ram[pre_a] <= pre_d;
      else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
   end

   int ncmp = 0, nfail = 0;
   logic [31:0] tr_a [0:15];
   logic        tr_wr[0:15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      pre_a = a[15:0];
      pre_d = d;
      pre_we = 1'b1;
      shadow[a[15:0]] = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   function automatic int nb(input logic [1:0] sz);
      return (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                              input bit sgn);
      int n;
      logic [31:0] v;
      n = nb(sz);
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(shadow[16'(a + 32'(i))]) << (8 * i));
      if (n < 4 && sgn && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      for (int i = 0; i < nb(sz); i++) shadow[16'(a + 32'(i))] = wd[8 * i +: 8];
   endtask

   // One load or store, requested in cycle 0; lat = cycle index of the done pulse.
   task automatic run_op(input bit is_st, input logic [31:0] a, input logic [1:0] sz,
                         input bit sgn, input logic [31:0] wd, input int io_rel,
                         input int frz_at, input int frz_len,
                         output logic [31:0] rdata, output int lat, output int nwr);
      lat = -1;
      nwr = 0;
      rdata = '0;
      if (is_st) begin
         st_req = 1'b1; st_addr = a; st_size = sz; st_data = wd;
         io_full = (io_rel > 0);
      end else begin
         ld_req = 1'b1; ld_addr = a; ld_size = sz; ld_signed = sgn;
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k < 16) begin tr_a[k] = mem_a; tr_wr[k] = mem_wr; end
         nwr += int'(mem_wr);
         if (is_st ? st_done : ld_done) begin
            lat = k;
            rdata = ld_data;
            break;
         end
         @(posedge clk); #1;
         io_full = (k + 1 < io_rel);
         rdy = !((k + 1) >= frz_at && (k + 1) < frz_at + frz_len);
      end
      @(posedge clk); #1;
      st_req = 1'b0; ld_req = 1'b0; rdy = 1'b1; io_full = 1'b0;
   endtask

   logic [31:0] rd, a;
   logic [1:0]  sz;
   int          lat, nwr, n, flen, fat, nev, nl, ndone;
   bit          found, is_st, sgn;
   int          ordv[4];
   int          expo[4] = '{0, 0, 1, 0};

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wr", 32'(mem_wr), 32'h0);
      chk("rst_mem_dout", 32'(mem_dout), 32'h0);
      chk("rst_if_done", 32'(if_done), 32'h0);
      chk("rst_ld_done", 32'(ld_done), 32'h0);
      chk("rst_st_done", 32'(st_done), 32'h0);
      chk("rst_ld_data", ld_data, 32'h0);
      chk("rst_if_data", if_data, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LW 0x100
      poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
      run_op(0, 32'h100, SZ_W, 0, 0, 0, 0, 0, rd, lat, nwr);
      chk("lw_data", rd, 32'h4433_2211);
      chk("lw_lat", 32'(lat), 32'd6);
      for (int k = 1; k <= 4; k++) chk("lw_addr", tr_a[k], 32'h100 + 32'(k - 1));

      // LB signed / LHU at 0x200
      poke(32'h200, 8'h80); poke(32'h201, 8'hFF);
      run_op(0, 32'h200, SZ_B, 1, 0, 0, 0, 0, rd, lat, nwr);
      chk("lb_data", rd, 32'hFFFF_FF80);
      chk("lb_lat", 32'(lat), 32'd3);
      run_op(0, 32'h200, SZ_H, 0, 0, 0, 0, 0, rd, lat, nwr);
      chk("lhu_data", rd, 32'h0000_FF80);
      chk("lhu_lat", 32'(lat), 32'd4);

      // SH 0x300
      poke(32'h300, 8'h00); poke(32'h301, 8'h00); poke(32'h302, 8'h5A);
      run_op(1, 32'h300, SZ_H, 0, 32'hAABB_CCDD, 0, 0, 0, rd, lat, nwr);
      model_store(32'h300, SZ_H, 32'hAABB_CCDD);
      chk("sh_lat", 32'(lat), 32'd3);
      chk("sh_nwr", 32'(nwr), 32'd2);
      chk("sh_b0", 32'(ram[16'h300]), 32'hDD);
      chk("sh_b1", 32'(ram[16'h301]), 32'hCC);
      chk("sh_b2_untouched", 32'(ram[16'h302]), 32'h5A);

      // Asynchronous reset in the middle of a read
      ld_req = 1'b1; ld_addr = 32'h100; ld_size = SZ_W; ld_signed = 1'b0;
      repeat (3) @(negedge clk);
      chk("arst_before", mem_a, 32'h101);
      rst_n = 1'b0;
      #1;
      chk("arst_mem_a", mem_a, 32'h0);
      ld_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Burst limit: fetch and loads held together
      for (int i = 0; i < 4; i++) poke(32'h500 + 32'(i), 8'(8'h1C + 8'(i * 29)));
      for (int i = 0; i < 12; i++) poke(32'h600 + 32'(i), 8'(8'h03 + 8'(i * 7)));
      for (int i = 0; i < 4; i++) ordv[i] = 9;
      if_req = 1'b1; if_addr = 32'h500;
      ld_req = 1'b1; ld_addr = 32'h600; ld_size = SZ_W; ld_signed = 1'b1;
      nev = 0; nl = 0;
      for (int k = 0; k < 100 && nev < 4; k++) begin
         @(negedge clk);
         if (ld_done) begin
            ordv[nev] = 0;
            chk("arb_ld_data", ld_data, model_load(32'h600 + 32'(4 * nl), SZ_W, 1));
            nev++; nl++;
            @(posedge clk); #1;
            if (nl < 3) ld_addr = 32'h600 + 32'(4 * nl);
            else        ld_req = 1'b0;
         end else if (if_done) begin
            ordv[nev] = 1;
            chk("arb_if_data", if_data, model_load(32'h500, SZ_W, 0));
            nev++;
            @(posedge clk); #1;
            if_req = 1'b0;
         end
      end
      for (int i = 0; i < 4; i++) chk("arb_order", 32'(ordv[i]), 32'(expo[i]));
      if_req = 1'b0; ld_req = 1'b0;
      @(posedge clk); #1;

      // clear during LW byte 2
      ld_req = 1'b1; ld_addr = 32'h100; ld_size = SZ_W; ld_signed = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (mem_a == 32'h102) begin clear = 1'b1; ld_req = 1'b0; found = 1'b1; break; end
      end
      @(posedge clk); #1;
      clear = 1'b0; ld_req = 1'b0;
      @(negedge clk);
      chk("clr_ld_found", 32'(found), 32'd1);
      chk("clr_ld_idle", mem_a, 32'h0);
      ndone = 0;
      repeat (10) begin @(negedge clk); ndone += int'(ld_done); end
      chk("clr_ld_nodone", 32'(ndone), 32'd0);
      @(posedge clk); #1;

      // clear during SW: store is committed and completes
      st_req = 1'b1; st_addr = 32'h700; st_size = SZ_W; st_data = 32'h0102_0304;
      lat = -1; nwr = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         nwr += int'(mem_wr);
         clear = mem_wr && (mem_a == 32'h701);
         if (st_done) begin lat = k; break; end
      end
      @(posedge clk); #1;
      st_req = 1'b0; clear = 1'b0;
      model_store(32'h700, SZ_W, 32'h0102_0304);
      chk("clr_sw_lat", 32'(lat), 32'd5);
      chk("clr_sw_nwr", 32'(nwr), 32'd4);
      chk("clr_sw_b0", 32'(ram[16'h700]), 32'h04);
      chk("clr_sw_b3", 32'(ram[16'h703]), 32'h01);

      // SB to IO space with io_buffer_full for three write cycles
      run_op(1, 32'h0003_0000, SZ_B, 0, 32'h0000_00A5, 4, 0, 0, rd, lat, nwr);
      model_store(32'h0003_0000, SZ_B, 32'h0000_00A5);
      chk("io_lat", 32'(lat), 32'd5);
      chk("io_nwr", 32'(nwr), 32'd1);
      chk("io_wr_cycle", 32'(tr_wr[4]), 32'd1);
      chk("io_data", 32'(ram[16'h0000]), 32'hA5);

      // Address wrap past 2^32
      poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2);
      poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
      run_op(0, 32'hFFFF_FFFE, SZ_W, 0, 0, 0, 0, 0, rd, lat, nwr);
      chk("wrap_data", rd, 32'hD4C3_B2A1);
      chk("wrap_addr2", tr_a[3], 32'h0);
      chk("wrap_addr3", tr_a[4], 32'h1);

      // rdy freeze in the middle of a word load
      run_op(0, 32'h100, SZ_W, 0, 0, 0, 3, 2, rd, lat, nwr);
      chk("frz_data", rd, model_load(32'h100, SZ_W, 0));
      chk("frz_lat", 32'(lat), 32'd8);

      // Randomized loads/stores with occasional freezes
      for (int i = 0; i < 68; i++) poke(32'h1000 + 32'(i), 8'($urandom));
      for (int t = 0; t < 40; t++) begin
         is_st = 1'($urandom_range(0, 1));
         a     = 32'h1000 + 32'($urandom_range(0, 60));
         sz    = 2'($urandom_range(0, 3));
         sgn   = 1'($urandom_range(0, 1));
         st_data = $urandom;
         flen  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : 0;
         fat   = int'($urandom_range(1, 2));
         n     = nb(sz);
         run_op(is_st, a, sz, sgn, st_data, 0, fat, flen, rd, lat, nwr);
         if (is_st) begin
            model_store(a, sz, st_data);
            chk("rnd_st_lat", 32'(lat), 32'(n + 1 + flen));
            chk("rnd_st_nwr", 32'(nwr), 32'(n));
            for (int i = 0; i < n; i++)
               chk("rnd_st_byte", 32'(ram[16'(a + 32'(i))]), 32'(st_data[8 * i +: 8]));
         end else begin
            chk("rnd_ld_lat", 32'(lat), 32'(n + 2 + flen));
            chk("rnd_ld_data", rd, model_load(a, sz, sgn));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
